writeback_arbiter: RTL

//  Writeback stage directly upstream of the register file: merges the 1-cycle ALU result path and the

---
 rtl/writeback_arbiter_pkg.sv | 20 ++
 rtl/writeback_arbiter_wb_fifo.sv | 67 ++++++
 rtl/writeback_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter: register index, data word,
// the queued writeback entry and a one-hot helper used by the pending mask.
package writeback_arbiter_pkg;

    typedef logic [4:0]  reg_t;
    typedef logic [63:0] dword_t;

    typedef struct packed {
        reg_t   rd;
        dword_t wdata;
    } wb_entry_t;

    localparam int unsigned WB_DEPTH      = 4;
    localparam int unsigned WB_STARVE_MAX = 3;

    function automatic logic [31:0] rd_onehot(input reg_t rd);
        return 32'(1) << rd;
    endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Synchronous FIFO of writeback entries. Besides the usual head/full/empty it exposes
// per-slot valid bits and destination registers so the parent can build a pending mask.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  push,
    input  logic                  pop,
    input  wb_entry_t             din,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t             head,
    output logic [DEPTH-1:0]      entry_valid,
    output reg_t [DEPTH-1:0]      entry_rd
);

    localparam int unsigned AW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: slot contents are only ever observed through entry_valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_comb begin
        entry_valid = '0;
        entry_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] offset;
            offset         = AW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
            entry_rd[i]    = mem[i].rd;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: merges the ALU result path and the buffered LSU result path onto the
// single register-file write port, with ALU priority and a starvation stall on the ALU.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = WB_DEPTH,
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        alu_valid,
    input  reg_t        alu_rd,
    input  dword_t      alu_wdata,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  reg_t        lsu_rd,
    input  dword_t      lsu_wdata,
    output logic        alu_stall,
    output logic [31:0] pending,
    output logic        rf_RegWrite,
    output reg_t        rf_rd,
    output dword_t      rf_wdata
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    // LSU handshake: a transfer happens on a rising edge where lsu_valid && lsu_ready.
    // lsu_ready depends only on FIFO occupancy, never on lsu_valid or on a same-cycle pop.
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    wb_entry_t         fifo_head;
    logic [DEPTH-1:0]  entry_valid;
    reg_t [DEPTH-1:0]  entry_rd;
    logic              alu_win;
    logic [CW-1:0]     starve_cnt;

    assign lsu_ready = !fifo_full;
    assign fifo_push = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign alu_win   = alu_valid && (alu_rd != '0);
    assign fifo_pop  = !alu_win && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK         (CLK),
        .nRST        (nRST),
        .push        (fifo_push),
        .pop         (fifo_pop),
        .din         ('{rd: lsu_rd, wdata: lsu_wdata}),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rf_RegWrite <= 1'b0;
            rf_rd       <= '0;
            rf_wdata    <= '0;
        end else if (alu_win) begin
            rf_RegWrite <= 1'b1;
            rf_rd       <= alu_rd;
            rf_wdata    <= alu_wdata;
        end else if (fifo_pop) begin
            rf_RegWrite <= 1'b1;
            rf_rd       <= fifo_head.rd;
            rf_wdata    <= fifo_head.wdata;
        end else begin
            rf_RegWrite <= 1'b0;
        end
    end

    // The stall follows the counter by one edge, so it drops the edge after a pop clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else begin
            alu_stall <= (starve_cnt == CW'(STARVE_MAX));
            if (fifo_empty || fifo_pop) begin
                starve_cnt <= '0;
            end else if (alu_win && (starve_cnt != CW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) pending = pending | rd_onehot(entry_rd[i]);
        end
        if (rf_RegWrite) pending = pending | rd_onehot(rf_rd);
        pending[0] = 1'b0;
    end

endmodule
